cpu_csr: RTL and testbench



---
 rtl/cpu_csr.sv | 212 +++++++++++++++++++++
 tb/tb_cpu_csr.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_csr.sv
// AXI4 burst-capable slave exposing 8 x 32-bit CSRs; independent write and read FSMs.
// Optional CPU_CSR_ID_REG_EN: register 7 becomes read-only and returns ID_VALUE.
module cpu_csr #(
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 32,
  parameter int          ID_W     = 5,
  parameter logic [31:0] ID_VALUE = 32'hC5C0_0001
) (
  input  logic                s_aclk,
  input  logic                s_areset,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [1:0]          s_axi_awburst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [1:0]          s_axi_arburst,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid
);

  localparam int                NREG        = 2 ** (ADDR_W - 2);
  localparam logic [ADDR_W-3:0] ID_IDX      = ADDR_W'(NREG - 1) >> 0;
  localparam logic [1:0]        BURST_FIXED = 2'b00;
  localparam logic [2:0]        SIZE_W4     = 3'b010;
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [1:0]        W_IDLE      = 2'd0;
  localparam logic [1:0]        W_DATA      = 2'd1;
  localparam logic [1:0]        W_RESP      = 2'd2;
  localparam logic [0:0]        R_IDLE      = 1'b0;
  localparam logic [0:0]        R_DATA      = 1'b1;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0] burst);
    return (burst == BURST_FIXED) ? a : a + ADDR_W'(4);
  endfunction

  logic [DATA_W-1:0] regs_q [NREG];

  logic [1:0]        wstate_q, wstate_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [1:0]        wburst_q;
  logic [ID_W-1:0]   wid_q;
  logic              werr_q;
  logic [ADDR_W-3:0] widx;
  logic              w_beat, wr_en, id_hit_w;

  assign widx   = waddr_q[ADDR_W-1:2];
  assign w_beat = (wstate_q == W_DATA) && s_axi_wvalid;
`ifdef CPU_CSR_ID_REG_EN
  assign id_hit_w = (widx == ID_IDX);
`else
  assign id_hit_w = 1'b0;
`endif
  assign wr_en = w_beat && !werr_q && !id_hit_w;

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wcnt_d   = wcnt_q;
    case (wstate_q)
      W_IDLE: if (s_axi_awvalid) begin
        wstate_d = W_DATA;
        waddr_d  = s_axi_awaddr;
        wcnt_d   = s_axi_awlen;
      end
      W_DATA: if (s_axi_wvalid) begin
        waddr_d = next_addr(waddr_q, wburst_q);
        if (wcnt_q == 8'd0) wstate_d = W_RESP;
        else                wcnt_d   = wcnt_q - 8'd1;
      end
      W_RESP:  wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wcnt_q   <= '0;
      wburst_q <= '0;
      wid_q    <= '0;
      werr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wcnt_q   <= wcnt_d;
      if (wstate_q == W_IDLE && s_axi_awvalid) begin
        wburst_q <= s_axi_awburst;
        wid_q    <= s_axi_awid;
        werr_q   <= (s_axi_awsize != SIZE_W4);
      end
    end
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < DATA_W / 8; b++)
        if (s_axi_wstrb[b]) regs_q[widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  assign s_axi_awready = (wstate_q == W_IDLE);
  assign s_axi_wready  = (wstate_q == W_DATA);
  assign s_axi_bvalid  = (wstate_q == W_RESP);
  assign s_axi_bid     = wid_q;
  assign s_axi_bresp   = (wstate_q == W_RESP && werr_q) ? RESP_SLVERR : RESP_OKAY;

  // Read beats are preloaded: the beat on the bus at cycle N was fetched at the edge ending N-1.
  logic [0:0]        rstate_q;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [1:0]        rburst_q;
  logic              rerr_q, rerr_d;
  logic              rvalid_q, rlast_q;
  logic [DATA_W-1:0] rdata_q, rd_word;
  logic [ID_W-1:0]   rid_q;
  logic [1:0]        rresp_q;
  logic              r_load;
  logic [ADDR_W-3:0] ridx;

  always_comb begin
    raddr_d = next_addr(raddr_q, rburst_q);
    rerr_d  = rerr_q;
    rcnt_d  = rcnt_q - 8'd1;
    if (rstate_q == R_IDLE) begin
      raddr_d = s_axi_araddr;
      rerr_d  = (s_axi_arsize != SIZE_W4);
      rcnt_d  = s_axi_arlen;
    end
  end

  assign r_load = (rstate_q == R_IDLE) ? s_axi_arvalid : !rlast_q;
  assign ridx   = raddr_d[ADDR_W-1:2];

  always_comb begin
    rd_word = regs_q[ridx];
`ifdef CPU_CSR_ID_REG_EN
    if (ridx == ID_IDX) rd_word = ID_VALUE;
`endif
  end

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rcnt_q   <= '0;
      rburst_q <= '0;
      rerr_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (r_load) begin
      rstate_q <= R_DATA;
      raddr_q  <= raddr_d;
      rcnt_q   <= rcnt_d;
      rerr_q   <= rerr_d;
      rvalid_q <= 1'b1;
      rlast_q  <= (rcnt_d == 8'd0);
      rdata_q  <= rerr_d ? '0 : rd_word;
      rresp_q  <= rerr_d ? RESP_SLVERR : RESP_OKAY;
      if (rstate_q == R_IDLE) begin
        rburst_q <= s_axi_arburst;
        rid_q    <= s_axi_arid;
      end
    end else if (rstate_q == R_DATA) begin
      rstate_q <= R_IDLE;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= RESP_OKAY;
    end
  end

  assign s_axi_arready = (rstate_q == R_IDLE);
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;

  // wlast is informational only; beat count comes from awlen.
  logic unused_ok;
  assign unused_ok = ^{s_axi_wlast, ID_VALUE};

endmodule

// File: tb/tb_cpu_csr.sv
// Scoreboard bench for cpu_csr: expected B/R responses are queued when stimulus is driven
// and checked by a monitor on the falling edge.
module tb_cpu_csr;

  logic        s_aclk = 1'b0;
  logic        s_areset = 1'b1;
  logic [4:0]  s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [1:0]  s_axi_awburst = '0, s_axi_arburst = '0;
  logic [4:0]  s_axi_awid = '0, s_axi_arid = '0;
  logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0]  s_axi_awsize = '0, s_axi_arsize = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic        s_axi_awready, s_axi_arready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [4:0]  s_axi_bid, s_axi_rid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_rvalid, s_axi_rlast;
  logic [31:0] s_axi_rdata;

  cpu_csr dut (
    .s_aclk(s_aclk), .s_areset(s_areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awburst(s_axi_awburst), .s_axi_awid(s_axi_awid),
    .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst), .s_axi_arid(s_axi_arid),
    .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid)
  );

  always #5 s_aclk = ~s_aclk;

  typedef struct packed { logic [4:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [31:0] data; logic [4:0] id; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] mdl [8];
  int          tests_run = 0;
  int          fails = 0;

  function automatic logic [31:0] exp_reg(input int idx);
`ifdef CPU_CSR_ID_REG_EN
    if (idx == 7) return 32'hC5C0_0001;
`endif
    return mdl[idx];
  endfunction

  function automatic void mdl_write(input int idx, input logic [31:0] d, input logic [3:0] s);
`ifdef CPU_CSR_ID_REG_EN
    if (idx == 7) return;
`endif
    for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [4:0] nxt(input logic [4:0] a, input logic [1:0] burst);
    return (burst == 2'b00) ? a : 5'((a + 5'd4) & 5'h1F);
  endfunction

  function automatic logic ready_of(input int which);
    case (which)
      0:       return s_axi_awready;
      1:       return s_axi_wready;
      default: return s_axi_arready;
    endcase
  endfunction

  always @(negedge s_aclk) begin
    if (s_axi_bvalid === 1'b1) begin
      b_exp_t e;
      tests_run++;
      if (bq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_b bid=%h bresp=%b required no response", s_axi_bid, s_axi_bresp);
      end else begin
        e = bq.pop_front();
        if (s_axi_bid !== e.id || s_axi_bresp !== e.resp) begin
          fails++;
          $display("FAIL b_resp got bid=%h bresp=%b required bid=%h bresp=%b",
                   s_axi_bid, s_axi_bresp, e.id, e.resp);
        end
      end
    end
    if (s_axi_rvalid === 1'b1) begin
      r_exp_t e;
      tests_run++;
      if (rq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_r rdata=%h required no beat", s_axi_rdata);
      end else begin
        e = rq.pop_front();
        if (s_axi_rdata !== e.data || s_axi_rid !== e.id || s_axi_rresp !== e.resp ||
            s_axi_rlast !== e.last) begin
          fails++;
          $display("FAIL r_beat got data=%h id=%h resp=%b last=%b required data=%h id=%h resp=%b last=%b",
                   s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, e.data, e.id, e.resp, e.last);
        end
      end
    end else if (s_axi_rdata !== 32'h0 || s_axi_rlast !== 1'b0) begin
      tests_run++;
      fails++;
      $display("FAIL r_idle_zero got rdata=%h rlast=%b required 0", s_axi_rdata, s_axi_rlast);
    end
  end

  task automatic wait_hs(input int which, input string nm);
    int n = 0;
    while (ready_of(which) !== 1'b1 && n < 20) begin
      @(negedge s_aclk);
      n++;
    end
    if (n >= 20) begin
      tests_run++;
      fails++;
      $display("FAIL %s timeout ready=0 required 1", nm);
    end
    @(negedge s_aclk);
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [4:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input logic [31:0] base, input logic [3:0] strb);
    logic [4:0] a = addr;
    int n = 0;
    bq.push_back('{id: id, resp: (size != 3'b010) ? 2'b10 : 2'b00});
    @(negedge s_aclk);
    s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = len;
    s_axi_awburst = burst; s_axi_awsize = size; s_axi_awvalid = 1'b1;
    wait_hs(0, "aw_hs");
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = base + 32'(i); s_axi_wstrb = strb;
      s_axi_wlast = (i == int'(len)); s_axi_wvalid = 1'b1;
      if (size == 3'b010) mdl_write(int'(a[4:2]), base + 32'(i), strb);
      wait_hs(1, "w_hs");
      a = nxt(a, burst);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    tests_run++;
    if (s_axi_bvalid !== 1'b1) begin
      fails++;
      $display("FAIL b_latency bvalid=%b required 1", s_axi_bvalid);
    end
    while (bq.size() != 0 && n < 20) begin @(negedge s_aclk); n++; end
    if (n >= 20) begin
      tests_run++; fails++;
      $display("FAIL b_timeout pending=%0d required 0", bq.size());
      bq.delete();
    end
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [4:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
    logic [4:0] a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{data: (size == 3'b010) ? exp_reg(int'(a[4:2])) : 32'h0, id: id,
                     resp: (size == 3'b010) ? 2'b00 : 2'b10, last: (i == int'(len))});
      a = nxt(a, burst);
    end
    @(negedge s_aclk);
    s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = len;
    s_axi_arburst = burst; s_axi_arsize = size; s_axi_arvalid = 1'b1;
    wait_hs(2, "ar_hs");
    s_axi_arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      tests_run++;
      if (s_axi_rvalid !== 1'b1) begin
        fails++;
        $display("FAIL r_timing beat %0d rvalid=%b required 1", i, s_axi_rvalid);
      end
      @(negedge s_aclk);
    end
    tests_run++;
    if (s_axi_rvalid !== 1'b0 || rq.size() != 0) begin
      fails++;
      $display("FAIL r_end rvalid=%b pending=%0d required 0 and 0", s_axi_rvalid, rq.size());
      rq.delete();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    s_areset = 1'b1;
    repeat (3) @(negedge s_aclk);
    tests_run++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1 || s_axi_wready !== 1'b0 ||
        s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_bid !== 5'h0 ||
        s_axi_bresp !== 2'b00 || s_axi_rid !== 5'h0 || s_axi_rresp !== 2'b00) begin
      fails++;
      $display("FAIL reset_outputs got awr=%b arr=%b wr=%b bv=%b rv=%b required 1 1 0 0 0",
               s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid);
    end
    s_areset = 1'b0;
    axi_read(5'h00, 5'h01, 8'd7, 2'b01, 3'b010);
  endtask

  task automatic test_single();
    axi_write(5'h00, 5'h02, 8'd0, 2'b01, 3'b010, 32'hDEADBEEF, 4'b1111);
    axi_read(5'h00, 5'h03, 8'd0, 2'b01, 3'b010);
  endtask

  task automatic test_strobe();
    axi_write(5'h04, 5'h04, 8'd0, 2'b01, 3'b010, 32'hFFFFFFFF, 4'b1111);
    axi_write(5'h04, 5'h05, 8'd0, 2'b01, 3'b010, 32'h00000000, 4'b0101);
    axi_read(5'h04, 5'h06, 8'd0, 2'b01, 3'b010);
  endtask

  task automatic test_incr_wrap();
    axi_write(5'h18, 5'h07, 8'd3, 2'b01, 3'b010, 32'd1, 4'b1111);
    axi_read(5'h18, 5'h0A, 8'd3, 2'b01, 3'b010);
    axi_write(5'h10, 5'h08, 8'd1, 2'b11, 3'b010, 32'h5000, 4'b1111);
    axi_read(5'h1C, 5'h0B, 8'd2, 2'b10, 3'b010);
  endtask

  task automatic test_fixed_id();
    axi_write(5'h08, 5'h13, 8'd0, 2'b01, 3'b010, 32'h2222_AAAA, 4'b1111);
    axi_read(5'h08, 5'h0C, 8'd2, 2'b00, 3'b010);
    axi_write(5'h0C, 5'h0D, 8'd2, 2'b00, 3'b010, 32'h3000, 4'b1111);
    axi_read(5'h0C, 5'h0E, 8'd0, 2'b01, 3'b010);
  endtask

  task automatic test_size_err();
    axi_write(5'h0C, 5'h0F, 8'd0, 2'b01, 3'b001, 32'h1234, 4'b1111);
    axi_read(5'h0C, 5'h10, 8'd0, 2'b01, 3'b010);
    axi_read(5'h00, 5'h11, 8'd1, 2'b01, 3'b000);
  endtask

  task automatic test_reset_midburst();
    logic [4:0] a = 5'h00;
    @(negedge s_aclk);
    s_axi_awaddr = 5'h00; s_axi_awid = 5'h14; s_axi_awlen = 8'd3;
    s_axi_awburst = 2'b01; s_axi_awsize = 3'b010; s_axi_awvalid = 1'b1;
    wait_hs(0, "aw_hs_rst");
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_axi_wdata = 32'hA000 + 32'(i); s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      wait_hs(1, "w_hs_rst");
      a = nxt(a, 2'b01);
    end
    s_axi_wvalid = 1'b0;
    s_areset = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    repeat (2) @(negedge s_aclk);
    s_areset = 1'b0;
    repeat (3) @(negedge s_aclk);
    tests_run++;
    if (s_axi_awready !== 1'b1 || s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
      fails++;
      $display("FAIL rst_midburst awready=%b wready=%b bvalid=%b required 1 0 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid);
    end
    axi_read(5'h00, 5'h15, 8'd7, 2'b01, 3'b010);
  endtask

  task automatic test_id_reg();
    axi_write(5'h1C, 5'h16, 8'd0, 2'b01, 3'b010, 32'hAAAA5555, 4'b1111);
    axi_read(5'h1C, 5'h17, 8'd0, 2'b01, 3'b010);
  endtask

  initial begin
    test_reset();
    test_single();
    test_strobe();
    test_incr_wrap();
    test_fixed_id();
    test_size_err();
    test_reset_midburst();
    test_id_reg();
    repeat (3) @(negedge s_aclk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
